// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers (MIPS-style MDU).
// One radix-2 step per cycle; signed ops run on magnitudes and are fixed up in a final cycle.
module alu_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int CTR_BUS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CTR_BUS_WIDTH-1:0] op_code,
  input  logic [DATA_WIDTH-1:0]    data_a,
  input  logic [DATA_WIDTH-1:0]    data_b,
  output logic [DATA_WIDTH-1:0]    hi,
  output logic [DATA_WIDTH-1:0]    lo,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_MULT  = CTR_BUS_WIDTH'(3'b000);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_MULTU = CTR_BUS_WIDTH'(3'b001);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_DIV   = CTR_BUS_WIDTH'(3'b010);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_DIVU  = CTR_BUS_WIDTH'(3'b011);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_MTHI  = CTR_BUS_WIDTH'(3'b100);
  localparam logic [CTR_BUS_WIDTH-1:0] OP_MTLO  = CTR_BUS_WIDTH'(3'b101);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    acc_hi, acc_lo, opnd_b;
  logic            op_div, neg_res, neg_rem;

  logic            is_mul, is_dv, signed_op, sign_a, sign_b, launch, div_zero;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [W-1:0]    step_hi, step_lo, fix_hi, fix_lo;
  logic [2*W-1:0]  fix_prod;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_wide(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    is_mul    = start && (op_code == OP_MULT || op_code == OP_MULTU);
    is_dv     = start && (op_code == OP_DIV  || op_code == OP_DIVU);
    signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
    sign_a    = signed_op && data_a[W-1];
    sign_b    = signed_op && data_b[W-1];
    launch    = (state == IDLE) && (is_mul || (is_dv && data_b != '0));
    div_zero  = (state == IDLE) && is_dv && (data_b == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide on the shared accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    step_hi   = mul_sum[W:1];
    step_lo   = {mul_sum[0], acc_lo[W-1:1]};
    if (op_div) begin
      if (!div_diff[W]) begin
        step_hi = div_diff[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    fix_prod = cond_neg_wide({acc_hi, acc_lo}, neg_res);
    fix_hi   = op_div ? cond_neg(acc_hi, neg_rem) : fix_prod[2*W-1:W];
    fix_lo   = op_div ? cond_neg(acc_lo, neg_res) : fix_prod[W-1:0];
  end

  // Datapath working registers: no reset, only meaningful between launch and FIX.
  always_ff @(posedge clk) begin
    if (launch) begin
      acc_hi  <= '0;
      acc_lo  <= cond_neg(data_a, sign_a);
      opnd_b  <= cond_neg(data_b, sign_b);
      op_div  <= is_dv;
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) cnt <= CNT_INIT;
          if (div_zero) begin
            hi   <= data_a;
            lo   <= '1;
            done <= 1'b1;
          end
          if (start && op_code == OP_MTHI) hi <= data_a;
          if (start && op_code == OP_MTLO) lo <= data_a;
        end
        RUN: cnt <= cnt - CW'(1);
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: table of single operations plus hand-written
// sequences for start-while-busy and reset-abort behaviour.
module tb_alu_mdu;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    op_code;
  logic [DW-1:0] data_a, data_b, hi, lo;
  logic          busy, done;

  int compared = 0;
  int mismatched = 0;

  alu_mdu #(.DATA_WIDTH(DW), .CTR_BUS_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op_code(op_code),
    .data_a(data_a), .data_b(data_b), .hi(hi), .lo(lo),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            iter;
    bit            exp_done;
    logic [DW-1:0] exp_hi;
    logic [DW-1:0] exp_lo;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input bit iter, input bit ed, input logic [DW-1:0] eh, input logic [DW-1:0] el);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.iter = iter; v.exp_done = ed; v.exp_hi = eh; v.exp_lo = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bit hold_ok, saw_done;
    logic [DW-1:0] prev_hi, prev_lo;

    vecs[0]  = mk(3'b000, 32'hFFFFFFFD, 32'd5,        1, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    vecs[1]  = mk(3'b001, 32'hFFFFFFFF, 32'd2,        1, 1, 32'h00000001, 32'hFFFFFFFE);
    vecs[2]  = mk(3'b010, 32'hFFFFFFF9, 32'd2,        1, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    vecs[3]  = mk(3'b010, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h00000000, 32'h80000000);
    vecs[4]  = mk(3'b011, 32'd100,      32'd7,        1, 1, 32'd2,        32'd14);
    vecs[5]  = mk(3'b000, 32'd7,        32'hFFFFFFFE, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFF2);
    vecs[6]  = mk(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h00000000, 32'h00000001);
    vecs[7]  = mk(3'b010, 32'd7,        32'hFFFFFFFE, 1, 1, 32'h00000001, 32'hFFFFFFFD);
    vecs[8]  = mk(3'b011, 32'hFFFFFFFF, 32'h10,       1, 1, 32'h0000000F, 32'h0FFFFFFF);
    vecs[9]  = mk(3'b001, 32'h12345678, 32'h1000,     1, 1, 32'h00000123, 32'h45678000);
    vecs[10] = mk(3'b010, 32'h80000000, 32'd1,        1, 1, 32'h00000000, 32'h80000000);
    vecs[11] = mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFE, 32'h00000001);
    vecs[12] = mk(3'b100, 32'hA5A50001, 32'd9,        0, 0, 32'hA5A50001, 32'h00000001);
    vecs[13] = mk(3'b101, 32'h00001234, 32'd9,        0, 0, 32'hA5A50001, 32'h00001234);
    vecs[14] = mk(3'b110, 32'h0000FFFF, 32'd3,        0, 0, 32'hA5A50001, 32'h00001234);
    vecs[15] = mk(3'b011, 32'd7,        32'd0,        0, 1, 32'h00000007, 32'hFFFFFFFF);
    vecs[16] = mk(3'b010, 32'h80000000, 32'd0,        0, 1, 32'h80000000, 32'hFFFFFFFF);
    vecs[17] = mk(3'b111, 32'h0BADBEEF, 32'd4,        0, 0, 32'h80000000, 32'hFFFFFFFF);

    reset = 1'b1; start = 1'b0; op_code = '0; data_a = '0; data_b = '0;
    tick(); tick();
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_ctrl", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      prev_hi = hi; prev_lo = lo;
      op_code = vecs[i].op; data_a = vecs[i].a; data_b = vecs[i].b; start = 1'b1;
      tick();
      start = 1'b0;
      if (vecs[i].iter) begin
        check($sformatf("v%0d_busy_at_start", i), {63'd0, busy}, 64'd1);
        hold_ok = 1'b1;
        k = 0;
        while (k < 100) begin
          data_a = $urandom; data_b = $urandom;
          k++;
          tick();
          if (done) break;
          if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
        end
        check($sformatf("v%0d_latency", i), 64'(k), 64'(DW + 1));
        check($sformatf("v%0d_hilo_hold", i), {63'd0, hold_ok}, 64'd1);
        check($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        tick();
        check($sformatf("v%0d_done_pulse", i), {62'd0, busy, done}, 64'd0);
      end else begin
        check($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd0);
        check($sformatf("v%0d_done", i), {63'd0, done}, {63'd0, vecs[i].exp_done});
        check($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      end
    end

    tick();
    check("div0_done_single", {63'd0, done}, 64'd0);

    // MULTU 3*4 with an MTHI and a second MULT attempted mid-flight.
    prev_hi = hi; prev_lo = lo;
    op_code = 3'b001; data_a = 32'd3; data_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign_start", {63'd0, busy}, 64'd1);
    hold_ok = 1'b1;
    k = 0;
    while (k < 100) begin
      k++;
      if (k == 5) begin
        start = 1'b1; op_code = 3'b100; data_a = 32'h55; data_b = 32'd0;
      end else if (k == 8) begin
        start = 1'b1; op_code = 3'b000; data_a = 32'h99; data_b = 32'h7;
      end else begin
        start = 1'b0; data_a = $urandom; data_b = $urandom;
      end
      tick();
      if (done) break;
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
    end
    start = 1'b0;
    check("busy_ign_latency", 64'(k), 64'(DW + 1));
    check("busy_ign_hold", {63'd0, hold_ok}, 64'd1);
    check("busy_ign_hilo", {hi, lo}, {32'd0, 32'd12});
    tick();
    check("busy_ign_idle", {62'd0, busy, done}, 64'd0);

    // MTHI/MTLO, then DIV aborted by reset (coinciding with a fresh start).
    op_code = 3'b100; data_a = 32'h77; start = 1'b1;
    tick();
    op_code = 3'b101; data_a = 32'h1234;
    tick();
    start = 1'b0;
    check("mt_before_abort", {hi, lo}, {32'h77, 32'h1234});
    op_code = 3'b010; data_a = 32'd100; data_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1; start = 1'b1; op_code = 3'b001; data_a = 32'd3; data_b = 32'd3;
    tick();
    reset = 1'b0; start = 1'b0;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_ctrl", {62'd0, busy, done}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_residue", {63'd0, saw_done}, 64'd0);
    check("abort_hilo_end", {hi, lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and HI/LO register width; SHALL be even and >= 8.
REQ-002 Parameter CTR_BUS_WIDTH, default 3, width of op_code.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request strobe; SHALL be sampled only at a rising edge of clk.
REQ-006 op_code  input  CTR_BUS_WIDTH  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; all other codes are no-ops.
REQ-007 data_a  input  DATA_WIDTH  multiplicand, dividend, or MTHI/MTLO source.
REQ-008 data_b  input  DATA_WIDTH  multiplier or divisor.
REQ-009 hi  output  DATA_WIDTH  HI register: product upper half, or remainder.
REQ-010 lo  output  DATA_WIDTH  LO register: product lower half, or quotient.
REQ-011 busy  output  1  high while an iterative operation is in flight.
REQ-012 done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX; the block leaves reset in IDLE.
REQ-014 In IDLE, start=1 with a MULT/MULTU/DIV/DIVU op and a nonzero divisor SHALL latch the operand magnitudes, the sign flags and the op, load the iteration counter with DATA_WIDTH, and enter RUN; busy SHALL read 1 from the same edge.
REQ-015 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. The counter SHALL decrement each cycle, and the FSM SHALL enter FIX when the counter reaches 0.
REQ-016 FIX SHALL apply the sign correction for signed ops in one cycle, write hi/lo, assert done for exactly that one cycle, clear busy, and return to IDLE; total latency SHALL be start edge + DATA_WIDTH + 1 cycles.
REQ-017 Signed multiply SHALL negate the 2*DATA_WIDTH product when the operand signs differ; unsigned ops SHALL not negate.
REQ-018 Signed divide: the quotient sign SHALL be sign(a) XOR sign(b), and the remainder sign SHALL be sign(a); quotient truncates toward zero.
REQ-019 Signed most-negative / -1 SHALL yield lo = most-negative value and hi = 0, with no trap.
REQ-020 Divide by zero (data_b = 0, DIV or DIVU) SHALL bypass RUN: at the next edge hi = data_a, lo = all ones, and done = 1 for one cycle; busy SHALL stay 0.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write data_a to hi/lo at that edge; busy and done SHALL stay 0.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in flight or on hi/lo.
REQ-023 start with a no-op code SHALL have no effect.
REQ-024 hi/lo SHALL hold their previous values throughout RUN; only FIX, divide-by-zero, MTHI/MTLO or reset SHALL change them.
REQ-025 Operands SHALL be captured at start; input changes during RUN SHALL not affect the result.

Reset
REQ-026 With reset=1 at an edge: hi=0, lo=0, busy=0, done=0, FSM = IDLE, counter=0.
REQ-027 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL leave no residue in hi/lo.

Verification (DATA_WIDTH=32)
REQ-028 MULT, a=0xFFFFFFFD (-3), b=5 -> busy for 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-029 MULTU, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 33 cycles.
REQ-030 DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 DIVU, a=7, b=0 -> next edge hi=7, lo=0xFFFFFFFF, done=1, busy never 1.
REQ-032 MULTU 3*4 started, MTHI with a=0x55 issued at cycle 5 -> MTHI ignored; after 33 cycles hi=0, lo=12.
REQ-033 MTLO a=0x1234, then DIV started and reset=1 at cycle 10 -> next edge hi=0, lo=0, busy=0; no done pulse follows.
